braille_sequencer: RTL and testbench
====================================

# braille_sequencer

Playback controller for the 4-bit braille decoder. It holds a short message of character codes in a small register file and steps through it one character at a time. Each character is held for a fixed display time, with an optional blank gap between characters. At top level it sits between the SW/KEY inputs and the decoder. `code_out` drives the decoder's encoding input, and `code_valid` gates LEDR. Code 15 has no decoder pattern, so the controller uses it as the end-of-message terminator and never presents it.

## Interface
- `DEPTH`, 8: message slots; power of two, ≥2.
- `HOLD_CYCLES`, 25_000_000: cycles each character is displayed; ≥1.
- `GAP_CYCLES`, 5_000_000: blank cycles between characters; ≥1; used only with the gap feature.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state and message slots.
- `wr_en` in 1: write strobe for a message slot.
- `wr_addr` in $clog2(DEPTH): slot to write.
- `wr_data` in 4: character code, 0–14; 15 writes a terminator.
- `start` in 1: level-sampled; begins playback from slot 0.
- `stop` in 1: level-sampled; aborts playback.
- `code_out` out 4: current character code; 0 when not valid.
- `code_valid` out 1: a character is being displayed.
- `char_idx` out $clog2(DEPTH): slot being displayed or gapped after; 0 in IDLE.
- `busy` out 1: in SHOW or GAP.
- `done` out 1: one-cycle pulse when playback completes normally.

## Operation
- Registers: `mem[DEPTH]` of 4 bits, the state, the index, and a down-counter sized $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- Reset: all `mem` = 15 (empty message), state IDLE. All outputs are 0.
- States: IDLE, SHOW, GAP, DONE.
- Writes:
  - Accepted only when `busy` = 0 (IDLE or DONE); ignored otherwise.
  - A write commits on the edge where `wr_en` = 1.
- IDLE:
  - `start` = 1 and `stop` = 0 with `mem[0]` ≠ 15: go to SHOW with index 0 and counter = HOLD_CYCLES−1.
  - `start` = 1 and `stop` = 0 with `mem[0]` = 15: go to DONE.
  - `start` and `stop` both 1: `stop` wins and the block stays in IDLE.
- SHOW:
  - Outputs `code_out` = `mem[idx]`, `code_valid` = 1.
  - The counter decrements each cycle.
  - At counter 0 with idx = DEPTH−1 or `mem[idx+1]` = 15: go to DONE.
  - At counter 0 otherwise: go to GAP with counter = GAP_CYCLES−1.
- GAP:
  - Outputs `code_valid` = 0, `code_out` = 0, `char_idx` = idx.
  - At counter 0: idx++, go to SHOW with counter = HOLD_CYCLES−1.
- DONE: `done` = 1 for exactly one cycle, then IDLE. `start` is ignored in this cycle.
- `stop` in SHOW or GAP: next state IDLE with no `done` pulse. `mem` is preserved and the next `start` replays from slot 0.
- `start` while `busy` is ignored, so there is no restart.
- A write and `start` in the same IDLE cycle: the write commits, and playback shows the new value.
- Index never wraps: the last slot always ends playback.

## Timing
- `start` sampled at edge 0: the first character is visible on cycle 1. Latency is one cycle.
- With a gap, each character spans HOLD_CYCLES. Characters are separated by GAP_CYCLES invalid cycles.
- `done` is asserted on the cycle after the final SHOW cycle.
- Total busy cycles for N characters: N·HOLD + (N−1)·GAP.
- `stop` at edge k: `code_valid` = 0 and `busy` = 0 from cycle k+1.
- Reset mid-playback: all outputs are 0 on the next cycle and the message is cleared.
- All outputs are registered or decoded from registered state only; there are no combinational input→output paths.

## Configuration
- `BRAILLE_SEQ_GAP_EN` defined: GAP state present as above.
- `BRAILLE_SEQ_GAP_EN` undefined:
  - GAP is removed and GAP_CYCLES is unused.
  - SHOW at counter 0 goes directly to the next character.
  - The next character is visible on the following cycle with `code_valid` held high.
  - Busy cycles for N characters = N·HOLD.

## Test plan
Bench uses HOLD_CYCLES = 4, GAP_CYCLES = 2, DEPTH = 8.
- Reset, then `start` at cycle 0 → `done` = 1 at cycle 1 only; `code_valid` and `busy` stay 0.
- Write slots 0..2 = 1, 2, 3, then `start` at cycle 0, GAP_EN defined:
  - `code_out` = 1 for cycles 1–4, 2 for cycles 7–10, 3 for cycles 13–16.
  - `code_valid` = 0 in cycles 5–6 and 11–12.
  - `done` at cycle 17.
- Same messages with GAP_EN undefined → codes 1 / 2 / 3 on cycles 1–4 / 5–8 / 9–12; `done` at cycle 13.
- All 8 slots written 0..7, no terminator → slots 0–7 shown in order with `char_idx` 0–7; `done` after slot 7; no wrap to slot 0.
- Interference during playback of a 3-character message:
  - `stop` at cycle 6 → `busy` = 0 at cycle 7; no `done` pulse.
  - A write issued during `busy` is ignored.
  - Re-`start` replays 1, 2, 3.
- Synchronous `reset` asserted at cycle 8 of playback → all outputs 0 at cycle 9; a subsequent `start` gives an immediate `done`, since the message was cleared.

Source files
------------

// File: rtl/braille_sequencer.sv
// Braille message playback controller: steps through a small message store, holding each code.
// Optional inter-character blank gap is enabled by defining BRAILLE_SEQ_GAP_EN.
module braille_sequencer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [3:0]               wr_data,
  input  logic                     start,
  input  logic                     stop,
  output logic [3:0]               code_out,
  output logic                     code_valid,
  output logic [$clog2(DEPTH)-1:0] char_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
`ifdef BRAILLE_SEQ_GAP_EN
  localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES - 1);
`endif
  localparam logic [3:0] TERM = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
`ifdef BRAILLE_SEQ_GAP_EN
    GAP  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      mem [DEPTH];

  logic [AW-1:0]   nidx;
  logic [3:0]      mem0_eff;
  logic            last_char;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= TERM;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (wr_en && !busy) mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    nidx      = idx + AW'(1);
    // A same-cycle write to slot 0 must decide whether playback starts at all
    mem0_eff  = (wr_en && wr_addr == '0) ? wr_data : mem[0];
    last_char = (idx == AW'(DEPTH - 1)) || (mem[nidx] == TERM);
    case (state)
      IDLE: begin
        if (start && !stop) begin
          idx_n = '0;
          if (mem0_eff != TERM) begin
            state_n = SHOW;
            cnt_n   = HOLD_INIT;
          end else begin
            state_n = DONE;
          end
        end
      end
      SHOW: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (last_char) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
`ifdef BRAILLE_SEQ_GAP_EN
          state_n = GAP;
          cnt_n   = GAP_INIT;
`else
          idx_n   = nidx;
          cnt_n   = HOLD_INIT;
`endif
        end
      end
`ifdef BRAILLE_SEQ_GAP_EN
      GAP: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = SHOW;
          idx_n   = nidx;
          cnt_n   = HOLD_INIT;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    code_out   = '0;
    code_valid = 1'b0;
    char_idx   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      SHOW: begin
        code_out   = mem[idx];
        code_valid = 1'b1;
        char_idx   = idx;
        busy       = 1'b1;
      end
`ifdef BRAILLE_SEQ_GAP_EN
      GAP: begin
        char_idx = idx;
        busy     = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_braille_sequencer.sv
// Directed self-checking bench for braille_sequencer (HOLD=4, GAP=2, DEPTH=8).
module tb_braille_sequencer;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  localparam int GAPC  = 2;
`ifdef BRAILLE_SEQ_GAP_EN
  localparam int G = GAPC;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, wr_en, start, stop;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] code_out;
  logic       code_valid, busy, done;
  logic [2:0] char_idx;

  int errors = 0;
  int checks = 0;
  logic [3:0] msg [DEPTH];

  braille_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .code_out(code_out), .code_valid(code_valid),
    .char_idx(char_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write(input int a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Starts playback of msg[0..n-1] and checks every output through done and one idle cycle.
  task automatic run_msg(input string name, input int n);
    int total, per, k, off;
    logic [3:0] e_code;
    logic e_valid, e_busy, e_done;
    logic [2:0] e_idx;
    total = n * HOLD + (n - 1) * G;
    per   = HOLD + G;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      e_code = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
      if (c <= total) begin
        k = (c - 1) / per; off = (c - 1) % per;
        e_busy = 1'b1; e_idx = 3'(k);
        if (off < HOLD) begin e_valid = 1'b1; e_code = msg[k]; end
      end else if (c == total + 1) begin
        e_done = 1'b1;
      end
      checks++;
      if (code_out !== e_code) begin
        errors++; $display("FAIL %s code_out c=%0d got=%0d exp=%0d", name, c, code_out, e_code);
      end
      checks++;
      if (code_valid !== e_valid) begin
        errors++; $display("FAIL %s code_valid c=%0d got=%0b exp=%0b", name, c, code_valid, e_valid);
      end
      checks++;
      if (char_idx !== e_idx) begin
        errors++; $display("FAIL %s char_idx c=%0d got=%0d exp=%0d", name, c, char_idx, e_idx);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s busy c=%0d got=%0b exp=%0b", name, c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++; $display("FAIL %s done c=%0d got=%0b exp=%0b", name, c, done, e_done);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({code_out, code_valid, char_idx, busy, done} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {code_out, code_valid, char_idx, busy, done});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy, code_valid} !== 3'b100) begin
      errors++; $display("FAIL empty_start c1 got={done,busy,valid}=%b exp=100", {done, busy, code_valid});
    end
    tick();
    checks++;
    if ({done, busy, code_valid} !== 3'b000) begin
      errors++; $display("FAIL empty_start c2 got={done,busy,valid}=%b exp=000", {done, busy, code_valid});
    end
  endtask

  task automatic test_three_chars();
    do_reset();
    msg[0] = 4'd1; msg[1] = 4'd2; msg[2] = 4'd3;
    for (int i = 0; i < 3; i++) write(i, msg[i]);
    run_msg("three", 3);
  endtask

  task automatic test_full_no_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin msg[i] = 4'(i); write(i, msg[i]); end
    run_msg("full", DEPTH);
  endtask

  task automatic test_stop_and_write_busy();
    do_reset();
    msg[0] = 4'd1; msg[1] = 4'd2; msg[2] = 4'd3;
    for (int i = 0; i < 3; i++) write(i, msg[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      if (c == 3) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd9; start = 1'b1; end
      tick();
      wr_en = 1'b0; start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL stop_pre busy c=6 got=%0b exp=1", busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({busy, code_valid, done, code_out} !== 7'b0) begin
      errors++; $display("FAIL stop c=7 got={busy,valid,done,code}=%b exp=0", {busy, code_valid, done, code_out});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL stop_no_done c=8 got=%0b exp=0", done);
    end
    run_msg("replay", 3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) write(i, 4'(i + 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({code_out, code_valid, char_idx, busy, done} !== 10'b0) begin
      errors++; $display("FAIL reset_mid c=9 got=%h exp=0", {code_out, code_valid, char_idx, busy, done});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy, code_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_cleared got={done,busy,valid}=%b exp=100", {done, busy, code_valid});
    end
    tick();
  endtask

  task automatic test_write_with_start();
    do_reset();
    msg[0] = 4'd5;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd5;
    run_msg("write_start", 1);
    wr_en = 1'b0;
  endtask

  task automatic test_stop_beats_start();
    do_reset();
    write(0, 4'd7);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, done, code_valid} !== 3'b000) begin
      errors++; $display("FAIL stop_wins got={busy,done,valid}=%b exp=000", {busy, done, code_valid});
    end
  endtask

  initial begin
    test_reset();
    test_three_chars();
    test_full_no_wrap();
    test_stop_and_write_busy();
    test_reset_mid();
    test_write_with_start();
    test_stop_beats_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
